// File: rtl/memory_responder_pkg.sv
// memory_responder_pkg
//   Shared definitions for the memory responder: the two-state controller
//   encoding (program load, then CPU service).
package memory_responder_pkg;

    typedef enum logic {
        MEM_STATE_LOAD = 1'b0,
        MEM_STATE_RUN  = 1'b1
    } mem_state_t;

endpackage

// File: rtl/memory_responder_tristate_buffer.sv
// tristate_buffer
//   Drives a shared bus when enabled, releases it to high-Z otherwise.
//   Ports:
//     in      input  WIDTH  value to place on the bus
//     enable  input  1      1 = drive, 0 = high-Z
//     out     inout  WIDTH  shared bus
module tristate_buffer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic             enable,
    inout  wire  [WIDTH-1:0] out
);

    assign out = enable ? in : {WIDTH{1'bz}};

endmodule

// File: rtl/memory_responder.sv
// memory_responder
//   Target-side memory for the 8-bit CPU. After reset it streams a program
//   image into memory from address 0 while holding the CPU in reset, then
//   releases the CPU and serves its reads/writes on the shared data bus.
//   Ports:
//     clk, reset    system clock, synchronous active-high reset
//     addr_bus      CPU memory address
//     c_ri / c_ro   CPU write / read strobes
//     bus           shared tri-state data bus (driven only on a clean read)
//     load_valid, load_data, load_last, load_ready
//                   program loader byte stream handshake
//     cpu_reset     hold-off for the CPU while loading
//     bus_conflict  sticky flag: both strobes seen together in RUN
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_bus,
    input  logic                  c_ri,
    input  logic                  c_ro,
    inout  wire  [DATA_WIDTH-1:0] bus,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  cpu_reset,
    output logic                  bus_conflict
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    mem_state_t            state;
    mem_state_t            state_next;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  load_accept;
    logic                  load_done;
    logic                  bus_en;
    logic                  cpu_write;
    logic                  strobe_clash;

    assign load_accept  = load_valid && load_ready;
    // Either the flagged last byte or the byte filling the top address ends loading.
    assign load_done    = load_accept && (load_last || (load_addr == '1));
    assign cpu_write    = (state == MEM_STATE_RUN) && c_ri && !c_ro;
    assign strobe_clash = (state == MEM_STATE_RUN) && c_ri && c_ro;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MEM_STATE_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RUN is left only through reset
    always_comb begin
        state_next = state;
        case (state)
            MEM_STATE_LOAD: if (load_done) state_next = MEM_STATE_RUN;
            MEM_STATE_RUN:  state_next = MEM_STATE_RUN;
            default:        state_next = MEM_STATE_LOAD;
        endcase
    end

    // Output logic: all Moore except the bus enable, which follows the strobes
    always_comb begin
        load_ready = 1'b0;
        cpu_reset  = 1'b0;
        bus_en     = 1'b0;
        case (state)
            MEM_STATE_LOAD: begin
                load_ready = 1'b1;
                cpu_reset  = 1'b1;
            end
            MEM_STATE_RUN: begin
                bus_en = c_ro && !c_ri;
            end
            default: begin
                load_ready = 1'b0;
                cpu_reset  = 1'b0;
                bus_en     = 1'b0;
            end
        endcase
    end

    // Loader address counter, wraps naturally at the full depth
    always_ff @(posedge clk) begin
        if (reset) begin
            load_addr <= '0;
        end else if (load_accept) begin
            load_addr <= load_addr + ADDR_WIDTH'(1);
        end
    end

    // Memory array: never cleared; loader owns it in LOAD, CPU in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_accept) begin
                mem[load_addr] <= load_data;
            end else if (cpu_write) begin
                mem[addr_bus] <= bus;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_conflict <= 1'b0;
        end else if (strobe_clash) begin
            bus_conflict <= 1'b1;
        end
    end

    assign rd_data = mem[addr_bus];

    tristate_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_bus_drv (
        .in    (rd_data),
        .enable(bus_en),
        .out   (bus)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder. The bench drives the bus with 0x00
// whenever it expects the block to be high-Z, so any stray drive of a
// nonzero memory byte shows up as a nonzero bus value.
module tb_memory_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_bus;
    logic       c_ri;
    logic       c_ro;
    wire  [7:0] bus;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_reset;
    logic       bus_conflict;

    logic       drv_en;
    logic [7:0] drv_val;

    int n_total = 0;
    int n_pass  = 0;

    assign bus = drv_en ? drv_val : 8'bz;

    always #5 clk = ~clk;

    memory_responder #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_bus    (addr_bus),
        .c_ri        (c_ri),
        .c_ro        (c_ro),
        .bus         (bus),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_reset   (cpu_reset),
        .bus_conflict(bus_conflict)
    );

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic       ri;
        logic       ro;
        logic       den;
        logic [7:0] dval;
        logic [7:0] exp_bus;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        c_ri    = 1'b0;
        c_ro    = 1'b0;
        drv_en  = 1'b1;
        drv_val = 8'h00;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // CPU read with bench releasing the bus; value checked combinationally
    task automatic cpu_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr_bus = a;
        c_ro     = 1'b1;
        c_ri     = 1'b0;
        drv_en   = 1'b0;
        #1;
        check(name, bus, exp);
        tick();
        cpu_idle();
    endtask

    initial begin
        vecs[0] = '{"rd00", 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h1E};
        vecs[1] = '{"rd01", 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h2F};
        vecs[2] = '{"rd02", 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 8'hE0};
        vecs[3] = '{"rd03", 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF0};
        vecs[4] = '{"wr0f", 8'h0F, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A};
        vecs[5] = '{"rd0f", 8'h0F, 1'b0, 1'b1, 1'b0, 8'h00, 8'h5A};
        vecs[6] = '{"idleZ", 8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        vecs[7] = '{"wr10", 8'h10, 1'b1, 1'b0, 1'b1, 8'h33, 8'h33};
        vecs[8] = '{"rd10", 8'h10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33};
        vecs[9] = '{"rd02b", 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 8'hE0};

        reset      = 1'b1;
        addr_bus   = 8'h00;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        cpu_idle();

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_load_ready", load_ready, 1);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_conflict", bus_conflict, 0);
        check("rst_busZ", bus, 8'h00);

        // Four-byte program, last flagged on the 4th byte
        load_byte(8'h1E, 1'b0);
        load_byte(8'h2F, 1'b0);
        load_byte(8'hE0, 1'b0);
        check("load3_cpu_reset", cpu_reset, 1);
        check("load3_ready", load_ready, 1);
        load_byte(8'hF0, 1'b1);
        check("load4_cpu_reset", cpu_reset, 0);
        check("load4_ready", load_ready, 0);

        // RUN vector table
        for (int i = 0; i < 10; i++) begin
            addr_bus = vecs[i].addr;
            c_ri     = vecs[i].ri;
            c_ro     = vecs[i].ro;
            drv_en   = vecs[i].den;
            drv_val  = vecs[i].dval;
            #1;
            check(vecs[i].name, bus, vecs[i].exp_bus);
            tick();
        end
        cpu_idle();
        check("run_no_conflict", bus_conflict, 0);

        // Conflicting strobes: no write, no drive, sticky flag one edge later
        addr_bus = 8'h10;
        c_ri     = 1'b1;
        c_ro     = 1'b1;
        drv_en   = 1'b1;
        drv_val  = 8'h44;
        #1;
        check("clash_noDrive", bus, 8'h44);
        check("clash_flag_pre", bus_conflict, 0);
        tick();
        cpu_idle();
        check("clash_flag_set", bus_conflict, 1);
        cpu_read("clash_noWrite", 8'h10, 8'h33);
        tick();
        tick();
        check("clash_flag_hold", bus_conflict, 1);

        // Reset mid-run: back to LOAD, flag cleared
        pulse_reset();
        check("rerun_conflict_clr", bus_conflict, 0);
        check("rerun_cpu_reset", cpu_reset, 1);
        check("rerun_ready", load_ready, 1);

        // CPU strobes during LOAD are ignored
        addr_bus = 8'h02;
        c_ro     = 1'b1;
        #1;
        check("load_ro_busZ", bus, 8'h00);
        tick();
        c_ro    = 1'b0;
        c_ri    = 1'b1;
        drv_val = 8'hEE;
        tick();
        cpu_idle();

        // Partial load, reset, reload one byte
        load_byte(8'h55, 1'b0);
        load_byte(8'h66, 1'b0);
        reset = 1'b1;
        #1;
        check("midload_rst_cpu_reset", cpu_reset, 1);
        tick();
        reset = 1'b0;
        check("midload_after_cpu_reset", cpu_reset, 1);
        load_byte(8'h99, 1'b1);
        check("reload_cpu_reset", cpu_reset, 0);
        cpu_read("reload_rd00", 8'h00, 8'h99);
        cpu_read("reload_rd01", 8'h01, 8'h66);
        cpu_read("load_strobe_noWrite", 8'h02, 8'hE0);
        cpu_read("retain_rd0f", 8'h0F, 8'h5A);

        // Full-depth stream without load_last: wraps into RUN at 0xFF
        pulse_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                check("wrap_pre_ready", load_ready, 1);
                check("wrap_pre_cpu_reset", cpu_reset, 1);
            end
            load_byte(8'(i) ^ 8'hA5, 1'b0);
        end
        check("wrap_ready", load_ready, 0);
        check("wrap_cpu_reset", cpu_reset, 0);
        for (int i = 0; i < 3; i++) load_byte(8'h00, 1'b1);
        check("wrap_ready_hold", load_ready, 0);
        cpu_read("wrap_rd00", 8'h00, 8'hA5);
        cpu_read("wrap_rd80", 8'h80, 8'h25);
        cpu_read("wrap_rdff", 8'hFF, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
